// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: constants shared by the EX/MEM pipeline register, its
// forwarding unit and the bus interface.
//   DATA_W / REG_W   : default datapath and register-index widths
//   CTL_*            : bit positions inside the 4-bit control word
//                      {reg_write, mem_read, mem_write, branch}
//   FWD_*            : operand-select encodings driven on fwd_a / fwd_b
package ex_mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam int CTL_W         = 4;
    localparam int CTL_REG_WRITE = 3;
    localparam int CTL_MEM_READ  = 2;
    localparam int CTL_MEM_WRITE = 1;
    localparam int CTL_BRANCH    = 0;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF    = 2'b00;
    localparam fwd_t FWD_EXMEM = 2'b10;
    localparam fwd_t FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: every signal of the EX/MEM stage except clk/rst.
//   slave  modport : the stage itself (takes EX results and hazard inputs,
//                    drives the registered mem_* contents, redirect, fwd selects)
//   master modport : the surrounding pipeline / testbench
// Flow control: there is no ready. ex_valid qualifies the EX bundle; the
// stage accepts it at a rising edge unless stall or flush is high. stall
// holds everything, flush drops the held entry, and flush beats stall.
interface ex_mem_stage_if #(
    parameter int DATA_W = ex_mem_stage_pkg::DATA_W,
    parameter int REG_W  = ex_mem_stage_pkg::REG_W
);
    import ex_mem_stage_pkg::*;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_res;
    logic              ex_zero;
    logic [CTL_W-1:0]  ex_ctl;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_store_data;
    logic [DATA_W-1:0] ex_br_target;
    logic              stall;
    logic              flush;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_reg_write;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_W-1:0]  mem_rd;
    logic [CTL_W-1:0]  mem_ctl;
    logic              pc_src;
    logic [DATA_W-1:0] pc_target;
    fwd_t              fwd_a;
    fwd_t              fwd_b;

    modport slave (
        input  ex_valid, ex_alu_res, ex_zero, ex_ctl, ex_rd, ex_store_data,
               ex_br_target, stall, flush, id_rs, id_rt, wb_rd, wb_reg_write,
        output mem_valid, mem_alu_res, mem_store_data, mem_rd, mem_ctl,
               pc_src, pc_target, fwd_a, fwd_b
    );

    modport master (
        output ex_valid, ex_alu_res, ex_zero, ex_ctl, ex_rd, ex_store_data,
               ex_br_target, stall, flush, id_rs, id_rt, wb_rd, wb_reg_write,
        input  mem_valid, mem_alu_res, mem_store_data, mem_rd, mem_ctl,
               pc_src, pc_target, fwd_a, fwd_b
    );

endinterface

// File: rtl/ex_mem_stage_fwd_unit.sv
// fwd_unit: operand-select logic for one source register of the instruction
// currently in EX. Purely combinational.
//   mem_valid, mem_reg_write, mem_rd : what the EX/MEM register holds
//   wb_reg_write, wb_rd              : what MEM/WB is about to write
//   src                              : source register index being resolved
//   sel                              : FWD_EXMEM, FWD_MEMWB or FWD_RF
module fwd_unit #(
    parameter int REG_W = ex_mem_stage_pkg::REG_W
) (
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [REG_W-1:0] src,
    output logic [1:0]       sel
);
    import ex_mem_stage_pkg::*;

    // The EX/MEM result is younger than MEM/WB, so it is checked first.
    // r0 is hard-wired to zero and must never be forwarded.
    always_comb begin
        sel = FWD_RF;
        if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution and the
// forwarding unit for the instruction in EX.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ex_mem_stage_if.slave
//              in : ex_* bundle, stall, flush, id_rs/id_rt, wb_rd/wb_reg_write
//              out: mem_* registered contents, pc_src/pc_target, fwd_a/fwd_b
module ex_mem_stage #(
    parameter int DATA_W = ex_mem_stage_pkg::DATA_W,
    parameter int REG_W  = ex_mem_stage_pkg::REG_W
) (
    input  logic           clk,
    input  logic           rst,
    ex_mem_stage_if.slave  bus
);
    import ex_mem_stage_pkg::*;

    logic              valid_q;
    logic [DATA_W-1:0] alu_q;
    logic              zero_q;
    logic [CTL_W-1:0]  ctl_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] target_q;
    // Set once the held branch has redirected the PC, so a stalled branch
    // does not redirect again on every held cycle.
    logic              br_done_q;

    logic [CTL_W-1:0]  ctl_eff;
    logic              taken;
    logic              redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            zero_q    <= 1'b0;
            ctl_q     <= '0;
            rd_q      <= '0;
            store_q   <= '0;
            target_q  <= '0;
            br_done_q <= 1'b0;
        end else if (bus.flush) begin
            // Dropping valid is enough: every consumer is gated by it.
            valid_q   <= 1'b0;
            br_done_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q   <= bus.ex_valid;
            alu_q     <= bus.ex_alu_res;
            zero_q    <= bus.ex_zero;
            ctl_q     <= bus.ex_ctl;
            rd_q      <= bus.ex_rd;
            store_q   <= bus.ex_store_data;
            target_q  <= bus.ex_br_target;
            br_done_q <= 1'b0;
        end else if (redirect) begin
            br_done_q <= 1'b1;
        end
    end

    // An invalid entry must never look like a write to memory or the regfile.
    assign ctl_eff  = valid_q ? ctl_q : '0;

    // The branch stays in the stage after redirecting; younger stages are
    // killed by the pipeline controller, not here.
    assign taken    = valid_q && ctl_q[CTL_BRANCH] && zero_q;
    assign redirect = taken && !br_done_q;

    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_res    = alu_q;
    assign bus.mem_store_data = store_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_ctl        = ctl_eff;
    assign bus.pc_src         = redirect;
    assign bus.pc_target      = redirect ? target_q : '0;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .mem_valid     (valid_q),
        .mem_reg_write (ctl_eff[CTL_REG_WRITE]),
        .mem_rd        (rd_q),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .src           (bus.id_rs),
        .sel           (bus.fwd_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .mem_valid     (valid_q),
        .mem_reg_write (ctl_eff[CTL_REG_WRITE]),
        .mem_rd        (rd_q),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .src           (bus.id_rt),
        .sel           (bus.fwd_b)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage. Inputs are driven 1ns
// after the rising edge and outputs are sampled there too, away from the
// edge. Expected values are hand-computed constants; loaded ALU results also
// go through a small expected queue.
module tb_ex_mem_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic sb_push(input logic [31:0] alu);
        exp_q.push_back(alu);
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.mem_alu_res, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_res    = '0;
        bus.ex_zero       = 1'b0;
        bus.ex_ctl        = '0;
        bus.ex_rd         = '0;
        bus.ex_store_data = '0;
        bus.ex_br_target  = '0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.id_rs         = '0;
        bus.id_rt         = '0;
        bus.wb_rd         = '0;
        bus.wb_reg_write  = 1'b0;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic z,
                            input logic [3:0] ctl, input logic [4:0] rd,
                            input logic [31:0] st, input logic [31:0] tgt);
        bus.ex_valid      = v;
        bus.ex_alu_res    = alu;
        bus.ex_zero       = z;
        bus.ex_ctl        = ctl;
        bus.ex_rd         = rd;
        bus.ex_store_data = st;
        bus.ex_br_target  = tgt;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_ctl",   32'(bus.mem_ctl),   32'd0);
        check("rst_alu",       bus.mem_alu_res,    32'd0);
        check("rst_pc_src",    32'(bus.pc_src),    32'd0);
        check("rst_pc_target", bus.pc_target,      32'd0);
        check("rst_fwd_a",     32'(bus.fwd_a),     32'd0);
        check("rst_fwd_b",     32'(bus.fwd_b),     32'd0);

        // load rd=3 reg_write, then forward to rs=3
        drive_ex(1'b1, 32'h0000_0005, 1'b0, 4'b1000, 5'd3, 32'h0000_00AA, 32'h0);
        sb_push(32'h0000_0005);
        step();
        check("ld_mem_valid", 32'(bus.mem_valid), 32'd1);
        sb_check("ld_alu");
        check("ld_mem_rd",  32'(bus.mem_rd),  32'd3);
        check("ld_mem_ctl", 32'(bus.mem_ctl), 32'h8);
        bus.stall = 1'b1;
        bus.id_rs = 5'd3;
        bus.id_rt = 5'd4;
        #1;
        check("fwd_a_exmem", 32'(bus.fwd_a), 32'h2);
        check("fwd_b_nomatch", 32'(bus.fwd_b), 32'h0);

        // both stages match rt=3: EX/MEM wins; then stage goes empty
        bus.wb_rd        = 5'd3;
        bus.wb_reg_write = 1'b1;
        bus.id_rt        = 5'd3;
        #1;
        check("fwd_b_prio", 32'(bus.fwd_b), 32'h2);
        bus.stall = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 4'b1000, 5'd3, 32'h0, 32'h0);
        step();
        check("empty_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("empty_mem_ctl",   32'(bus.mem_ctl),   32'd0);
        check("fwd_b_memwb",     32'(bus.fwd_b),     32'h1);
        check("fwd_a_memwb",     32'(bus.fwd_a),     32'h1);
        bus.wb_reg_write = 1'b0;
        #1;
        check("fwd_b_none", 32'(bus.fwd_b), 32'h0);

        // r0 never forwarded
        drive_ex(1'b1, 32'h0000_0007, 1'b0, 4'b1000, 5'd0, 32'h0, 32'h0);
        step();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.wb_rd        = 5'd0;
        bus.wb_reg_write = 1'b1;
        #1;
        check("r0_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("r0_fwd_a", 32'(bus.fwd_a), 32'h0);
        check("r0_fwd_b", 32'(bus.fwd_b), 32'h0);
        bus.wb_reg_write = 1'b0;

        // stall holds contents while EX presents something else
        drive_ex(1'b1, 32'h0000_0011, 1'b0, 4'b1100, 5'd9, 32'h0000_0022, 32'h0);
        sb_push(32'h0000_0011);
        step();
        sb_check("hold_load_alu");
        bus.stall = 1'b1;
        drive_ex(1'b1, 32'h0000_0099, 1'b0, 4'b1000, 5'd10, 32'h0000_0033, 32'h0);
        step();
        check("hold_alu",   bus.mem_alu_res,       32'h0000_0011);
        check("hold_rd",    32'(bus.mem_rd),       32'd9);
        check("hold_ctl",   32'(bus.mem_ctl),      32'hC);
        check("hold_store", bus.mem_store_data,    32'h0000_0022);
        bus.stall = 1'b0;

        // branch with zero=0 is not taken
        drive_ex(1'b1, 32'h0, 1'b0, 4'b0001, 5'd0, 32'h0, 32'h0040_0040);
        step();
        check("nt_pc_src",    32'(bus.pc_src), 32'd0);
        check("nt_pc_target", bus.pc_target,   32'd0);

        // taken branch then 3 stall cycles: exactly one pc_src cycle
        drive_ex(1'b1, 32'h0, 1'b1, 4'b0001, 5'd0, 32'h0, 32'h0040_0020);
        step();
        check("br_pc_src",    32'(bus.pc_src), 32'd1);
        check("br_pc_target", bus.pc_target,   32'h0040_0020);
        bus.stall = 1'b1;
        drive_ex(1'b1, 32'h0, 1'b1, 4'b0001, 5'd0, 32'h0, 32'h0000_0123);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("br_stall%0d_pc_src", i),    32'(bus.pc_src),    32'd0);
            check($sformatf("br_stall%0d_pc_target", i), bus.pc_target,      32'd0);
            check($sformatf("br_stall%0d_valid", i),     32'(bus.mem_valid), 32'd1);
        end
        bus.stall = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
        step();
        check("br_after_pc_src", 32'(bus.pc_src),    32'd0);
        check("br_after_valid",  32'(bus.mem_valid), 32'd0);

        // flush beats stall on a valid store
        drive_ex(1'b1, 32'h0000_0100, 1'b0, 4'b0010, 5'd0, 32'h0000_DEAD, 32'h0);
        step();
        check("st_mem_ctl",   32'(bus.mem_ctl),   32'h2);
        check("st_store",     bus.mem_store_data, 32'h0000_DEAD);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush_valid", 32'(bus.mem_valid), 32'd0);
        check("flush_ctl",   32'(bus.mem_ctl),    32'd0);
        bus.flush = 1'b0;
        step();
        check("flush_hold_valid", 32'(bus.mem_valid), 32'd0);
        bus.stall = 1'b0;

        // reset aborts a stalled taken branch
        drive_ex(1'b1, 32'h0000_0044, 1'b1, 4'b1001, 5'd7, 32'h0000_0055, 32'h0040_0080);
        step();
        check("rb_pc_src", 32'(bus.pc_src), 32'd1);
        bus.stall = 1'b1;
        step();
        check("rb_stall_pc_src", 32'(bus.pc_src),    32'd0);
        check("rb_stall_valid",  32'(bus.mem_valid), 32'd1);
        bus.id_rs = 5'd7;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rb_valid",     32'(bus.mem_valid),   32'd0);
        check("rb_ctl",       32'(bus.mem_ctl),     32'd0);
        check("rb_alu",       bus.mem_alu_res,      32'd0);
        check("rb_store",     bus.mem_store_data,   32'd0);
        check("rb_rd",        32'(bus.mem_rd),      32'd0);
        check("rb_pc_src",    32'(bus.pc_src),      32'd0);
        check("rb_pc_target", bus.pc_target,        32'd0);
        check("rb_fwd_a",     32'(bus.fwd_a),       32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rb_post%0d_pc_src", i), 32'(bus.pc_src), 32'd0);
        end
        bus.stall = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 4'b0000, 5'd0, 32'h0, 32'h0);
        step();
        check("rb_release_pc_src", 32'(bus.pc_src), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ex_valid  input  1  EX-stage result present this cycle.
REQ-006 SHALL have port ex_alu_res  input  DATA_W  ALU result from EX.
REQ-007 SHALL have port ex_zero  input  1  ALU zero flag from EX.
REQ-008 SHALL have port ex_ctl  input  4  {reg_write, mem_read, mem_write, branch}.
REQ-009 SHALL have port ex_rd  input  REG_W  destination register.
REQ-010 SHALL have port ex_store_data  input  DATA_W  store operand (rt value).
REQ-011 SHALL have port ex_br_target  input  DATA_W  computed branch target.
REQ-012 SHALL have port stall  input  1  MEM stall; hold stage contents.
REQ-013 SHALL have port flush  input  1  external kill of stage contents.
REQ-014 SHALL have port id_rs, id_rt  input  REG_W each  source indices of the instruction in EX.
REQ-015 SHALL have port wb_rd, wb_reg_write  input  REG_W, 1  MEM/WB destination and write enable.
REQ-016 SHALL have port mem_valid, mem_alu_res, mem_store_data, mem_rd, mem_ctl  output  1/DATA_W/DATA_W/REG_W/4  registered stage contents.
REQ-017 SHALL have port pc_src, pc_target  output  1, DATA_W  taken-branch redirect.
REQ-018 SHALL have port fwd_a, fwd_b  output  2 each  operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-019 Latency SHALL be one cycle: EX inputs sampled at edge N appear on mem_* after edge N.
REQ-020 When stall=1 and flush=0, all stage registers SHALL hold their values.
REQ-021 When flush=1, mem_valid SHALL clear at the next edge, regardless of stall (flush wins).
REQ-022 When stall=0 and flush=0, the stage SHALL load EX inputs; mem_valid<=ex_valid.
REQ-023 When mem_valid=0, mem_ctl SHALL read as 4'b0000 so that no write reaches memory or the regfile.
REQ-024 A taken branch SHALL be detected when mem_valid, branch and the latched zero flag are all 1.
REQ-025 pc_src SHALL pulse exactly one cycle per taken branch, even if stall holds the branch in the stage for several cycles; a registered br_done flag, cleared when a new entry loads, SHALL enforce this.
REQ-026 pc_target SHALL equal the latched ex_br_target whenever pc_src=1, and 0 otherwise.
REQ-027 A taken branch SHALL NOT kill its own entry; external logic flushes younger stages.
REQ-028 fwd_a SHALL be 10 when mem_valid, reg_write, mem_rd!=0 and mem_rd==id_rs; otherwise 01 when wb_reg_write, wb_rd!=0 and wb_rd==id_rs; otherwise 00. fwd_b SHALL follow the same rule using id_rt.
REQ-029 EX/MEM forwarding SHALL take priority over MEM/WB when both match.
REQ-030 Register 0 SHALL never be forwarded.
REQ-031 fwd_a/fwd_b SHALL be combinational from the current stage state and inputs.

Reset
REQ-032 On rst=1 at an edge, mem_valid, br_done and all mem_* data and control outputs SHALL become 0; pc_src, pc_target, fwd_a and fwd_b SHALL then read 0.
REQ-033 rst SHALL override stall and flush, and SHALL abort a held (stalled) taken branch with no pc_src pulse.

Structure
REQ-034 A shared package SHALL hold DATA_W and REG_W, the ex_ctl bit positions, and the fwd encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB).
REQ-035 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated twice (operands A and B).

Verification
REQ-036 Scenario: load alu_res=0x00000005, rd=3, reg_write=1, then id_rs=3 -> fwd_a=10 and mem_alu_res=0x5 one cycle later.
REQ-037 Scenario: rd=3 in stage and wb_rd=3 with wb_reg_write=1, id_rt=3 -> fwd_b=10; with mem_valid=0 -> fwd_b=01.
REQ-038 Scenario: rd=0 with reg_write=1 and id_rs=0 -> fwd_a=00.
REQ-039 Scenario: branch=1, zero=1, target=0x00400020, followed by stall for 3 cycles -> pc_src high exactly 1 cycle with pc_target=0x00400020.
REQ-040 Scenario: stall=1 and flush=1 in the same cycle on a valid store -> mem_valid=0 and mem_ctl=0000 next cycle.
REQ-041 Scenario: rst pulse while a taken branch is stalled -> all outputs 0 next cycle, and no pc_src pulse after release.
